// File: rtl/max7219_scroller.sv
// Scrolling frame buffer feeding the MAX7219 driver: queued columns enter at the right edge.
// Define SCROLL_WRAP_EN to recirculate the leftmost column when the column FIFO runs dry.
`timescale 1ns/1ps
module max7219_scroller #(
  parameter int SEG_ROWS       = 1,
  parameter int SEG_COLS       = 1,
  parameter int SCROLL_CYCLES  = 1000,
  parameter int COL_FIFO_DEPTH = 4
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst,
  input  logic                                  i_Enable,
  input  logic                                  i_Clear,
  input  logic                                  i_Col_Valid,
  input  logic [SEG_ROWS*8-1:0]                 i_Col_Data,
  output logic                                  o_Col_Ready,
  output logic [SEG_ROWS*8-1:0][SEG_COLS*8-1:0] o_FrameBuf,
  output logic                                  o_Frame_Update,
  output logic                                  o_Underflow,
  output logic [15:0]                           o_Shift_Count
);

  localparam int H  = SEG_ROWS * 8;
  localparam int W  = SEG_COLS * 8;
  localparam int AW = $clog2(COL_FIFO_DEPTH);
  localparam int CW = $clog2(SCROLL_CYCLES);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCROLL_CYCLES - 2);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(COL_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_PAUSED,
    ST_COUNTING,
    ST_SHIFT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          do_shift;

  logic [H-1:0]  fifo_mem [0:COL_FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  logic [H-1:0]         ins_col;
  logic [H-1:0][W-1:0]  frame_shift;
  logic                 underflow_d;

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == FIFO_FULL);
  assign o_Col_Ready = !fifo_full && !i_Clear && !i_Rst;
  assign push        = i_Col_Valid && o_Col_Ready;
  assign pop         = do_shift && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_shift = 1'b0;
    unique case (state_q)
      ST_PAUSED: begin
        if (i_Enable) state_d = ST_COUNTING;
      end
      ST_COUNTING: begin
        if (!i_Enable) begin
          state_d = ST_PAUSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        do_shift = 1'b1;
        state_d  = i_Enable ? ST_COUNTING : ST_PAUSED;
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  always_comb begin
    ins_col = fifo_empty ? '0 : fifo_mem[rd_ptr];
`ifdef SCROLL_WRAP_EN
    if (fifo_empty) begin
      for (int y = 0; y < H; y++) ins_col[y] = o_FrameBuf[y][0];
    end
`endif
    for (int y = 0; y < H; y++) begin
      frame_shift[y] = {ins_col[y], o_FrameBuf[y][W-1:1]};
    end
  end

`ifdef SCROLL_WRAP_EN
  assign underflow_d = 1'b0;
`else
  assign underflow_d = do_shift && fifo_empty;
`endif

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_Clk) begin
    if (push) fifo_mem[wr_ptr] <= i_Col_Data;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      state_q        <= ST_PAUSED;
      cnt_q          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      o_FrameBuf     <= '0;
      o_Frame_Update <= 1'b0;
      o_Underflow    <= 1'b0;
      o_Shift_Count  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (do_shift) begin
        o_FrameBuf    <= frame_shift;
        o_Shift_Count <= o_Shift_Count + 16'd1;
      end
      o_Frame_Update <= do_shift;
      o_Underflow    <= underflow_d;
    end
  end

endmodule

// File: tb/tb_max7219_scroller.sv
// Directed bench for max7219_scroller (8x8 frame, 4-clock shift period, 4-deep FIFO).
// Build with SCROLL_WRAP_EN defined to check the marquee variant.
`timescale 1ns/1ps
module tb_max7219_scroller;

`ifdef SCROLL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            clr;
  logic            vld;
  logic [7:0]      data;
  logic            rdy;
  logic [7:0][7:0] fb;
  logic            upd;
  logic            unf;
  logic [15:0]     scnt;

  int checks = 0;
  int errors = 0;

  max7219_scroller #(
    .SEG_ROWS(1),
    .SEG_COLS(1),
    .SCROLL_CYCLES(4),
    .COL_FIFO_DEPTH(4)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Enable(en),
    .i_Clear(clr),
    .i_Col_Valid(vld),
    .i_Col_Data(data),
    .o_Col_Ready(rdy),
    .o_FrameBuf(fb),
    .o_Frame_Update(upd),
    .o_Underflow(unf),
    .o_Shift_Count(scnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic        vld;
    logic [7:0]  data;
    logic        exp_rdy;
    logic [63:0] exp_fb;
    logic        exp_upd;
    logic        exp_unf;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input logic v, input logic [7:0] d,
                              input logic ry, input logic [63:0] f,
                              input logic u, input logic uf,
                              input logic [15:0] n);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.vld = v; t.data = d;
    t.exp_rdy = ry; t.exp_fb = f; t.exp_upd = u; t.exp_unf = uf;
    t.exp_cnt = n;
    return t;
  endfunction

  function automatic logic [7:0] col_at(input logic [63:0] f, input int x);
    logic [7:0] c;
    for (int y = 0; y < 8; y++) c[y] = f[y*8+x];
    return c;
  endfunction

  function automatic logic [63:0] shl(input logic [63:0] f,
                                      input logic [7:0] ins);
    logic [63:0] r;
    for (int y = 0; y < 8; y++) r[y*8 +: 8] = {ins[y], f[y*8+1 +: 7]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1; en = 1'b0; vld = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  logic [63:0] expf;
  logic [63:0] orig;
  logic [7:0]  ins;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0; data = 8'h00;

    vt[0]  = mk(1,0,0,0,8'h00, 0, 64'h0, 0,0, 0);
    vt[1]  = mk(0,0,0,1,8'hFF, 1, 64'h0, 0,0, 0);
    vt[2]  = mk(0,1,0,0,8'h00, 1, 64'h0, 0,0, 0);
    vt[3]  = mk(0,1,0,0,8'h00, 1, 64'h0, 0,0, 0);
    vt[4]  = mk(0,1,0,0,8'h00, 1, 64'h0, 0,0, 0);
    vt[5]  = mk(0,1,0,0,8'h00, 1, 64'h0, 0,0, 0);
    vt[6]  = mk(0,1,0,0,8'h00, 1, 64'h8080808080808080, 1,0, 1);
    vt[7]  = mk(0,1,0,0,8'h00, 1, 64'h8080808080808080, 0,0, 1);
    vt[8]  = mk(0,1,0,0,8'h00, 1, 64'h8080808080808080, 0,0, 1);
    vt[9]  = mk(0,1,0,0,8'h00, 1, 64'h8080808080808080, 0,0, 1);
    vt[10] = mk(0,1,0,0,8'h00, 1, 64'h4040404040404040, 1,!WRAP, 2);
    vt[11] = mk(0,1,0,0,8'h00, 1, 64'h4040404040404040, 0,0, 2);
    vt[12] = mk(0,1,0,0,8'h00, 1, 64'h4040404040404040, 0,0, 2);
    vt[13] = mk(0,1,0,0,8'h00, 1, 64'h4040404040404040, 0,0, 2);
    vt[14] = mk(1,1,0,1,8'hAA, 0, 64'h0, 0,0, 0);
    vt[15] = mk(0,0,0,0,8'h00, 1, 64'h0, 0,0, 0);

    #1;
    for (int i = 0; i < 16; i++) begin
      rst = vt[i].rst; en = vt[i].en; clr = vt[i].clr;
      vld = vt[i].vld; data = vt[i].data;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(rdy), 64'(vt[i].exp_rdy));
      tick();
      check($sformatf("vec%0d_frame", i), fb, vt[i].exp_fb);
      check($sformatf("vec%0d_update", i), 64'(upd), 64'(vt[i].exp_upd));
      check($sformatf("vec%0d_underflow", i), 64'(unf), 64'(vt[i].exp_unf));
      check($sformatf("vec%0d_count", i), 64'(scnt), 64'(vt[i].exp_cnt));
    end

    // FIFO fill while paused, back-pressure, in-order release
    do_clear();
    for (int k = 1; k <= 4; k++) begin
      vld = 1'b1; data = 8'(k);
      #1;
      check($sformatf("fill%0d_ready", k), 64'(rdy), 64'd1);
      tick();
    end
    data = 8'h05;
    #1;
    check("full_ready", 64'(rdy), 64'd0);
    tick();
    check("full_ready_held", 64'(rdy), 64'd0);
    en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("full_wait%0d_ready", n), 64'(rdy), 64'd0);
    end
    tick();
    check("first_shift_update", 64'(upd), 64'd1);
    check("first_shift_col", 64'(col_at(fb, 7)), 64'h01);
    check("ready_after_shift", 64'(rdy), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      for (int n = 1; n <= 4; n++) begin
        tick();
        vld = 1'b0;
        if (n < 4) begin
          check($sformatf("col%0d_gap%0d_update", k, n), 64'(upd), 64'd0);
        end else begin
          check($sformatf("col%0d_update", k), 64'(upd), 64'd1);
          check($sformatf("col%0d_value", k), 64'(col_at(fb, 7)), 64'(k));
          check($sformatf("col%0d_underflow", k), 64'(unf), 64'd0);
        end
      end
    end
    expf = '0;
    for (int x = 3; x <= 7; x++) begin
      for (int y = 0; y < 8; y++) expf[y*8+x] = ((x - 2) >> y) & 1;
    end
    check("order_frame", fb, expf);
    check("order_count", 64'(scnt), 64'd5);

    // Empty FIFO: blank insertion with underflow, or wrap-around
    do_clear();
    check("clear_frame", fb, 64'h0);
    check("clear_count", 64'(scnt), 64'd0);
    vld = 1'b1; data = 8'h81;
    tick();
    vld = 1'b0; en = 1'b1;
    for (int n = 1; n <= 5; n++) tick();
    orig = 64'h8000000000000080;
    check("pattern_loaded", fb, orig);
    expf = orig;
    for (int s = 1; s <= 8; s++) begin
      for (int n = 1; n <= 4; n++) tick();
      ins  = WRAP ? col_at(expf, 0) : 8'h00;
      expf = shl(expf, ins);
      check($sformatf("drain%0d_frame", s), fb, expf);
      check($sformatf("drain%0d_underflow", s), 64'(unf), 64'(!WRAP));
    end
    check("drain_final", fb, WRAP ? orig : 64'h0);

    // Clear landing on a SHIFT cycle with two queued columns
    do_clear();
    for (int k = 1; k <= 3; k++) begin
      vld = 1'b1; data = 8'(k * 8'h11);
      tick();
    end
    vld = 1'b0; en = 1'b1;
    for (int n = 1; n <= 5; n++) tick();
    check("pre_clear_col", 64'(col_at(fb, 7)), 64'h11);
    for (int n = 1; n <= 3; n++) tick();
    clr = 1'b1; vld = 1'b1; data = 8'h77;
    #1;
    check("clear_shift_ready", 64'(rdy), 64'd0);
    tick();
    clr = 1'b0; vld = 1'b0;
    check("clear_shift_frame", fb, 64'h0);
    check("clear_shift_count", 64'(scnt), 64'd0);
    check("clear_shift_update", 64'(upd), 64'd0);
    check("clear_shift_underflow", 64'(unf), 64'd0);
    for (int n = 1; n <= 4; n++) tick();
    check("post_clear_early", 64'(upd), 64'd0);
    tick();
    check("post_clear_update", 64'(upd), 64'd1);
    check("post_clear_col", 64'(col_at(fb, 7)), 64'h00);
    check("post_clear_underflow", 64'(unf), 64'(!WRAP));
    check("post_clear_count", 64'(scnt), 64'd1);

    // Pause with the tick counter at 1, then resume
    do_clear();
    vld = 1'b1; data = 8'h3C;
    tick();
    vld = 1'b0; en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("pause%0d_update", n), 64'(upd), 64'd0);
    end
    check("pause_frame", fb, 64'h0);
    en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 4) begin
        check($sformatf("resume%0d_update", n), 64'(upd), 64'd0);
      end else begin
        check("resume_update", 64'(upd), 64'd1);
        check("resume_col", 64'(col_at(fb, 7)), 64'h3C);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
